// File: rtl/draw_tank.sv
// Overlays one player tank (hull plus directional barrel) on the map pixel stream, with a 2-cycle pipeline.
// Optional DRAW_TANK_CLIP_EN restricts tank pixels to the playfield interior.
module draw_tank #(
  parameter int          HULL_SIZE  = 24,
  parameter int          BARREL_LEN = 12,
  parameter int          BARREL_W   = 4,
  parameter logic [11:0] HULL_RGB   = 12'h2_6_1,
  parameter logic [11:0] BARREL_RGB = 12'h1_3_0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos_in,
  input  logic [9:0]  ypos_in,
  input  logic [1:0]  dir_in,
  input  logic        pos_valid_in,
  output logic        pos_ready_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [11:0] HS  = 12'(HULL_SIZE);
  localparam logic [11:0] BL  = 12'(BARREL_LEN);
  localparam logic [11:0] BW  = 12'(BARREL_W);
  localparam logic [11:0] OFS = 12'((HULL_SIZE - BARREL_W) / 2);
  localparam logic [11:0] ONE = 12'd1;

  logic [10:0] act_x_q, act_x_d, pend_x_q, pend_x_d;
  logic [9:0]  act_y_q, act_y_d, pend_y_q, pend_y_d;
  logic [1:0]  act_dir_q, act_dir_d, pend_dir_q, pend_dir_d;
  logic        pend_full_q, pend_full_d, vblnk_prev_q, vblnk_prev_d;

  logic        hull_hit_p1_q, hull_hit_p1_d, barrel_hit_p1_q, barrel_hit_p1_d;
  logic [10:0] hcount_p1_q, hcount_p2_q;
  logic [9:0]  vcount_p1_q, vcount_p2_q;
  logic        hsync_p1_q, vsync_p1_q, hblnk_p1_q, vblnk_p1_q;
  logic        hsync_p2_q, vsync_p2_q, hblnk_p2_q, vblnk_p2_q;
  logic [11:0] rgb_p1_q, rgb_p2_q, rgb_p2_d;

  logic [11:0] h12, v12, ax12, ay12;
  logic        bar_hcol, bar_vrow, in_win, vblnk_rise;

  assign pos_ready_out = ~pend_full_q;

  // Stage 0: handshake, frame update and hit test against the active set.
  // All compares keep offsets on the counter side so nothing underflows near 0.
  always_comb begin
    h12  = {1'b0, hcount_in};
    v12  = {2'b0, vcount_in};
    ax12 = {1'b0, act_x_q};
    ay12 = {2'b0, act_y_q};

    act_x_d      = act_x_q;
    act_y_d      = act_y_q;
    act_dir_d    = act_dir_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    pend_dir_d   = pend_dir_q;
    pend_full_d  = pend_full_q;
    vblnk_prev_d = vblnk_in;
    vblnk_rise   = vblnk_in && !vblnk_prev_q;

    if (vblnk_rise && pend_full_q) begin
      act_x_d     = pend_x_q;
      act_y_d     = pend_y_q;
      act_dir_d   = pend_dir_q;
      pend_full_d = 1'b0;
    end
    if (pos_valid_in && !pend_full_q) begin
      pend_x_d    = xpos_in;
      pend_y_d    = ypos_in;
      pend_dir_d  = dir_in;
      pend_full_d = 1'b1;
    end

`ifdef DRAW_TANK_CLIP_EN
    in_win = (h12 >= 12'd2) && (h12 <= 12'd766) && (v12 >= 12'd2) && (v12 <= 12'd765);
`else
    in_win = 1'b1;
`endif

    bar_hcol = (h12 >= ax12 + OFS) && (h12 <= ax12 + OFS + BW - ONE);
    bar_vrow = (v12 >= ay12 + OFS) && (v12 <= ay12 + OFS + BW - ONE);

    hull_hit_p1_d = in_win && (h12 >= ax12) && (h12 <= ax12 + HS - ONE)
                           && (v12 >= ay12) && (v12 <= ay12 + HS - ONE);
    unique case (act_dir_q)
      2'd0:    barrel_hit_p1_d = bar_hcol && (v12 + BL >= ay12) && (v12 + ONE <= ay12);
      2'd1:    barrel_hit_p1_d = bar_vrow && (h12 >= ax12 + HS) && (h12 <= ax12 + HS + BL - ONE);
      2'd2:    barrel_hit_p1_d = bar_hcol && (v12 >= ay12 + HS) && (v12 <= ay12 + HS + BL - ONE);
      default: barrel_hit_p1_d = bar_vrow && (h12 + BL >= ax12) && (h12 + ONE <= ax12);
    endcase
    barrel_hit_p1_d = barrel_hit_p1_d && in_win;

    if (hblnk_p1_q || vblnk_p1_q) rgb_p2_d = 12'h000;
    else if (barrel_hit_p1_q)     rgb_p2_d = BARREL_RGB;
    else if (hull_hit_p1_q)       rgb_p2_d = HULL_RGB;
    else                          rgb_p2_d = rgb_p1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_x_q         <= 11'd384;
      act_y_q         <= 10'd372;
      act_dir_q       <= 2'd0;
      pend_x_q        <= '0;
      pend_y_q        <= '0;
      pend_dir_q      <= '0;
      pend_full_q     <= 1'b0;
      vblnk_prev_q    <= 1'b0;
      hull_hit_p1_q   <= 1'b0;
      barrel_hit_p1_q <= 1'b0;
      hcount_p1_q     <= '0;
      vcount_p1_q     <= '0;
      hsync_p1_q      <= 1'b0;
      vsync_p1_q      <= 1'b0;
      hblnk_p1_q      <= 1'b0;
      vblnk_p1_q      <= 1'b0;
      rgb_p1_q        <= '0;
      hcount_p2_q     <= '0;
      vcount_p2_q     <= '0;
      hsync_p2_q      <= 1'b0;
      vsync_p2_q      <= 1'b0;
      hblnk_p2_q      <= 1'b0;
      vblnk_p2_q      <= 1'b0;
      rgb_p2_q        <= '0;
    end else begin
      act_x_q         <= act_x_d;
      act_y_q         <= act_y_d;
      act_dir_q       <= act_dir_d;
      pend_x_q        <= pend_x_d;
      pend_y_q        <= pend_y_d;
      pend_dir_q      <= pend_dir_d;
      pend_full_q     <= pend_full_d;
      vblnk_prev_q    <= vblnk_prev_d;
      // Stage 1: hit flags plus delayed timing and map colour.
      hull_hit_p1_q   <= hull_hit_p1_d;
      barrel_hit_p1_q <= barrel_hit_p1_d;
      hcount_p1_q     <= hcount_in;
      vcount_p1_q     <= vcount_in;
      hsync_p1_q      <= hsync_in;
      vsync_p1_q      <= vsync_in;
      hblnk_p1_q      <= hblnk_in;
      vblnk_p1_q      <= vblnk_in;
      rgb_p1_q        <= rgb_in;
      // Stage 2: composited colour and output timing.
      hcount_p2_q     <= hcount_p1_q;
      vcount_p2_q     <= vcount_p1_q;
      hsync_p2_q      <= hsync_p1_q;
      vsync_p2_q      <= vsync_p1_q;
      hblnk_p2_q      <= hblnk_p1_q;
      vblnk_p2_q      <= vblnk_p1_q;
      rgb_p2_q        <= rgb_p2_d;
    end
  end

  assign hcount_out = hcount_p2_q;
  assign vcount_out = vcount_p2_q;
  assign hsync_out  = hsync_p2_q;
  assign vsync_out  = vsync_p2_q;
  assign hblnk_out  = hblnk_p2_q;
  assign vblnk_out  = vblnk_p2_q;
  assign rgb_out    = rgb_p2_q;

endmodule

// File: tb/tb_draw_tank.sv
// Scoreboard bench for draw_tank: each driven pixel pushes its expected output, popped two cycles later.
module tb_draw_tank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, xpos_in, hcount_out;
  logic [9:0]  vcount_in, ypos_in, vcount_out;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, rgb_out;
  logic [1:0]  dir_in;
  logic        pos_valid_in, pos_ready_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  int m_ax, m_ay, m_ad, m_px, m_py, m_pd;
  bit m_pf, m_vd;

  always #5 clk = ~clk;

  draw_tank dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .xpos_in(xpos_in), .ypos_in(ypos_in), .dir_in(dir_in),
    .pos_valid_in(pos_valid_in), .pos_ready_out(pos_ready_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int h, input int v, input logic [11:0] rgb,
                                          input bit hb, input bit vb);
    bit hull, bar;
    if (hb || vb) return 12'h000;
    hull = h >= m_ax && h <= m_ax + 23 && v >= m_ay && v <= m_ay + 23;
    case (m_ad)
      0:       bar = h >= m_ax + 10 && h <= m_ax + 13 && v >= m_ay - 12 && v <= m_ay - 1;
      1:       bar = h >= m_ax + 24 && h <= m_ax + 35 && v >= m_ay + 10 && v <= m_ay + 13;
      2:       bar = h >= m_ax + 10 && h <= m_ax + 13 && v >= m_ay + 24 && v <= m_ay + 35;
      default: bar = h >= m_ax - 12 && h <= m_ax - 1  && v >= m_ay + 10 && v <= m_ay + 13;
    endcase
`ifdef DRAW_TANK_CLIP_EN
    if (!(h >= 2 && h <= 766 && v >= 2 && v <= 765)) begin
      hull = 1'b0;
      bar  = 1'b0;
    end
`endif
    if (bar)  return 12'h130;
    if (hull) return 12'h261;
    return rgb;
  endfunction

  function automatic void model_reset();
    m_ax = 384; m_ay = 372; m_ad = 0;
    m_pf = 1'b0; m_vd = 1'b0;
    exp_q.delete();
  endfunction

  // Drive one pixel, advance the reference state across the edge, compare what emerges.
  task automatic pix(input int h, input int v, input bit hb, input bit vb);
    logic [11:0] rgb;
    bit hs, vs, rise, xfer;
    logic [36:0] got;
    rgb = 12'($urandom);
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    hcount_in = 11'(h); vcount_in = 10'(v);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    exp_q.push_back({11'(h), 10'(v), hs, vs, hb, vb, exp_rgb(h, v, rgb, hb, vb)});
    rise = vb && !m_vd;
    xfer = pos_valid_in && !m_pf;
    if (rise && m_pf) begin
      m_ax = m_px; m_ay = m_py; m_ad = m_pd; m_pf = 1'b0;
    end else if (xfer) begin
      m_px = int'(xpos_in); m_py = int'(ypos_in); m_pd = int'(dir_in); m_pf = 1'b1;
    end
    m_vd = vb;
    @(posedge clk); #1;
    if (exp_q.size() >= 2) begin
      got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
      check("pix", 64'(got), 64'(exp_q.pop_front()));
    end
    check("ready", 64'(pos_ready_out), 64'(!m_pf));
  endtask

  task automatic req(input int x, input int y, input int d);
    pos_valid_in = 1'b1;
    xpos_in = 11'(x); ypos_in = 10'(y); dir_in = 2'(d);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 64'(pos_ready_out), 64'd1);
    check("rst_out", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
    xpos_in = '0; ypos_in = '0; dir_in = '0; pos_valid_in = 0;
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;

    // Default tank at 384/372 facing up.
    pix(384, 372, 0, 0);
    pix(394, 360, 0, 0);
    pix(383, 372, 0, 0);
    pix(407, 395, 0, 0);
    pix(397, 371, 0, 0);
    pix(384, 372, 1, 0);
    pix(390, 380, 0, 1);
    for (int i = 0; i < 40; i++)
      pix(370 + $urandom_range(0, 50), 350 + $urandom_range(0, 50), $urandom_range(0, 7) == 0, 0);

    // Mid-frame request: old position persists until vblank rises.
    req(100, 200, 1);
    pix(10, 10, 0, 0);
    pos_valid_in = 1'b0;
    pix(384, 372, 0, 0);
    pix(124, 210, 0, 0);
    pix(394, 360, 0, 0);
    pix(0, 768, 0, 1);
    pix(124, 210, 0, 0);
    pix(135, 213, 0, 0);
    pix(110, 205, 0, 0);
    pix(384, 372, 0, 0);

    // Request coinciding with vblank rise takes effect one frame later.
    req(5, 5, 3);
    pix(0, 768, 0, 1);
    pos_valid_in = 1'b0;
    pix(0, 15, 0, 0);
    pix(124, 210, 0, 0);
    pix(0, 769, 0, 1);
    pix(0, 0, 0, 0);
    pix(0, 770, 0, 1);
    pix(0, 15, 0, 0);
    pix(4, 18, 0, 0);
    pix(5, 5, 0, 0);
    pix(2, 14, 0, 0);
    pix(28, 28, 0, 0);

    // Random pixels near the tank with random requests and frame boundaries.
    for (int i = 0; i < 400; i++) begin
      int h, v;
      if (!m_pf && $urandom_range(0, 9) == 0)
        req($urandom_range(0, 1000), $urandom_range(0, 740), $urandom_range(0, 3));
      else
        pos_valid_in = 1'b0;
      h = m_ax - 16 + $urandom_range(0, 56);
      v = m_ay - 16 + $urandom_range(0, 56);
      if (h < 0) h = 0;
      if (h > 1023) h = 1023;
      if (v < 0) v = 0;
      if (v > 767) v = 767;
      pix(h, v, $urandom_range(0, 15) == 0, (i % 37) > 33);
    end
    pos_valid_in = 1'b0;
    pix(0, 0, 0, 0);

    // Reset with a request pending.
    req(50, 60, 2);
    pix(1, 1, 0, 0);
    pos_valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    pix(0, 768, 0, 1);
    pix(384, 372, 0, 0);
    pix(394, 360, 0, 0);
    pix(60, 84, 0, 0);
    pix(383, 372, 0, 0);
    pix(0, 0, 0, 0);
    pix(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
